// File: rtl/irrigation_timer_pkg.sv
// Shared types and constants for the irrigation MM:SS countdown timer.
// Presets are packed BCD {md, mu, sd, su}, 4 bits per digit.
package irrigation_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MD_MAX = 3;
    localparam int MU_MAX = 9;
    localparam int SD_MAX = 5;
    localparam int SU_MAX = 9;

    localparam logic [15:0] DEFAULT_SPRINKLER_PRESET = 16'h1500;
    localparam logic [15:0] DEFAULT_DRIP_PRESET      = 16'h3000;

    typedef struct packed {
        logic [1:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
    } digits_t;

    // The upper bits of the md and sd nibbles are dropped; legality is checked separately.
    function automatic digits_t preset_digits(input logic [15:0] preset);
        digits_t d;
        d.md = 2'(preset[15:12]);
        d.mu = preset[11:8];
        d.sd = 3'(preset[7:4]);
        d.su = preset[3:0];
        return d;
    endfunction

    function automatic bit preset_is_legal(input logic [15:0] preset);
        return (int'(preset[15:12]) <= MD_MAX) && (int'(preset[11:8]) <= MU_MAX) &&
               (int'(preset[7:4])   <= SD_MAX) && (int'(preset[3:0])  <= SU_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: load has priority, a decrement at zero wraps to MAX
// and requests a borrow from the next more significant digit.
module bcd_digit_down #(
    parameter int WIDTH = 4,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec_in,
    output logic [WIDTH-1:0] digit,
    output logic             borrow_out
);

    logic [WIDTH-1:0] r_digit;
    logic             w_zero;

    assign w_zero     = (r_digit == '0);
    assign borrow_out = dec_in & w_zero;
    assign digit      = r_digit;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= load_val;
        end else if (dec_in) begin
            r_digit <= w_zero ? WIDTH'(MAX) : r_digit - 1'b1;
        end
    end

endmodule

// File: rtl/irrigation_countdown.sv
// BCD MM:SS irrigation countdown: loads a mode-selected preset on reload, counts down
// on 1 Hz ticks, supports pause, and pulses expired once when it reaches 00:00.
module irrigation_countdown
    import irrigation_timer_pkg::*;
#(
    parameter logic [15:0] SPRINKLER_PRESET = DEFAULT_SPRINKLER_PRESET,
    parameter logic [15:0] DRIP_PRESET      = DEFAULT_DRIP_PRESET
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       reload,
    input  logic       pause,
    input  logic       splinker_mode_on,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       running,
    output logic       expired
);

    if (!preset_is_legal(SPRINKLER_PRESET)) begin : g_bad_sprinkler_preset
        $fatal(1, "SPRINKLER_PRESET is not a legal BCD MM:SS value");
    end
    if (!preset_is_legal(DRIP_PRESET)) begin : g_bad_drip_preset
        $fatal(1, "DRIP_PRESET is not a legal BCD MM:SS value");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic       r_running;
    logic       r_expired;
    logic       w_running_next;
    logic       w_expired_next;
    logic       w_load;
    logic       w_dec;
    logic       w_zero;
    logic [15:0] w_preset;
    digits_t    w_load_digits;
    logic [1:0] w_md;
    logic [3:0] w_mu;
    logic [2:0] w_sd;
    logic [3:0] w_su;
    logic       w_su_borrow;
    logic       w_sd_borrow;
    logic       w_mu_borrow;
    logic       w_md_borrow;

    assign w_preset      = splinker_mode_on ? SPRINKLER_PRESET : DRIP_PRESET;
    assign w_load_digits = preset_digits(w_preset);
    assign w_zero        = (w_md == '0) && (w_mu == '0) && (w_sd == '0) && (w_su == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= w_running_next;
            r_expired <= w_expired_next;
        end
    end

    // NOTE: the default assignment at the top of each always_comb prevents latch inference.
    always_comb begin
        w_next_state = r_state;
        if (reload) begin
            w_next_state = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_zero) begin
                        w_next_state = DONE;
                    end else if (pause) begin
                        w_next_state = HOLD;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        w_next_state = RUN;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // Reload wins over everything, and the counter only moves in RUN when not at 00:00.
    always_comb begin
        w_load         = reload;
        w_dec          = !reload && (r_state == RUN) && !w_zero && !pause && tick;
        w_running_next = (w_next_state == RUN);
        w_expired_next = !reload && (r_state == RUN) && w_zero;
    end

    bcd_digit_down #(.WIDTH(4), .MAX(SU_MAX)) u_su (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_val   (w_load_digits.su),
        .dec_in     (w_dec),
        .digit      (w_su),
        .borrow_out (w_su_borrow)
    );

    bcd_digit_down #(.WIDTH(3), .MAX(SD_MAX)) u_sd (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_val   (w_load_digits.sd),
        .dec_in     (w_su_borrow),
        .digit      (w_sd),
        .borrow_out (w_sd_borrow)
    );

    bcd_digit_down #(.WIDTH(4), .MAX(MU_MAX)) u_mu (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_val   (w_load_digits.mu),
        .dec_in     (w_sd_borrow),
        .digit      (w_mu),
        .borrow_out (w_mu_borrow)
    );

    bcd_digit_down #(.WIDTH(2), .MAX(MD_MAX)) u_md (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .load_val   (w_load_digits.md),
        .dec_in     (w_mu_borrow),
        .digit      (w_md),
        .borrow_out (w_md_borrow)
    );

    // 00:00 is never decremented, so the tens-of-minutes digit can never be asked to borrow.
    always_comb begin
        assert (!w_md_borrow);
    end

    assign minutes_d = w_md;
    assign minutes_u = w_mu;
    assign seconds_d = w_sd;
    assign seconds_u = w_su;
    assign running   = r_running;
    assign expired   = r_expired;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Directed bench for irrigation_countdown: a seconds-based reference model pushes the
// expected outputs of each cycle into a scoreboard that is popped after the clock edge.
module tb_irrigation_countdown;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       reload = 1'b0;
    logic       pause = 1'b0;
    logic       splinker_mode_on = 1'b0;
    logic [1:0] minutes_d;
    logic [3:0] minutes_u;
    logic [2:0] seconds_d;
    logic [3:0] seconds_u;
    logic       running;
    logic       expired;

    irrigation_countdown dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tick             (tick),
        .reload           (reload),
        .pause            (pause),
        .splinker_mode_on (splinker_mode_on),
        .minutes_d        (minutes_d),
        .minutes_u        (minutes_u),
        .seconds_d        (seconds_d),
        .seconds_u        (seconds_u),
        .running          (running),
        .expired          (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [14:0] val;
    } exp_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_secs   = 0;
    int   m_state  = M_IDLE;
    bit   m_exp    = 1'b0;

    wire [14:0] dut_vec = {minutes_d, minutes_u, seconds_d, seconds_u, running, expired};

    function automatic int mmss(input int mm, input int ss);
        return mm * 60 + ss;
    endfunction

    function automatic logic [14:0] pack_time(input int secs, input bit run, input bit ex);
        int mins = secs / 60;
        int s    = secs % 60;
        return {2'(mins / 10), 4'(mins % 10), 3'(s / 10), 4'(s % 10), run, ex};
    endfunction

    function automatic void model_reset();
        m_secs  = 0;
        m_state = M_IDLE;
        m_exp   = 1'b0;
    endfunction

    function automatic void model_step(input bit rl, input bit pa, input bit tk, input bit md);
        bit at_zero = (m_secs == 0);
        m_exp = 1'b0;
        if (rl) begin
            m_secs  = md ? mmss(15, 0) : mmss(30, 0);
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (at_zero) begin
                m_state = M_DONE;
                m_exp   = 1'b1;
            end else if (pa) begin
                m_state = M_HOLD;
            end else if (tk) begin
                m_secs = m_secs - 1;
            end
        end else if (m_state == M_HOLD) begin
            if (!pa) m_state = M_RUN;
        end
    endfunction

    task automatic compare_head();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        assert (dut_vec === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, dut_vec, e.val);
        end
    endtask

    task automatic cycle(input bit rl, input bit pa, input bit tk, input bit md, input string tag);
        reload           = rl;
        pause            = pa;
        tick             = tk;
        splinker_mode_on = md;
        model_step(rl, pa, tk, md);
        sb.push_back('{tag, pack_time(m_secs, m_state == M_RUN, m_exp)});
        @(posedge clk);
        #1;
        compare_head();
        reload = 1'b0;
        pause  = 1'b0;
        tick   = 1'b0;
    endtask

    task automatic expect_now(input string tag, input int secs, input bit run, input bit ex);
        sb.push_back('{tag, pack_time(secs, run, ex)});
        compare_head();
    endtask

    task automatic run_ticks(input int n, input bit md);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, md, "count");
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        expect_now("reset_state", 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        cycle(1'b0, 1'b0, 1'b1, 1'b1, "idle_tick");
        expect_now("idle_holds_zero", 0, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 1'b1, 1'b1, "load_sprinkler");
        cycle(1'b1, 1'b0, 1'b1, 1'b1, "reload_held");
        expect_now("sprinkler_preset", mmss(15, 0), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "release");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "first_tick");
        expect_now("first_tick_1459", mmss(14, 59), 1'b1, 1'b0);

        run_ticks(299, 1'b1);
        expect_now("at_1000", mmss(10, 0), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "borrow_1000");
        expect_now("borrow_0959", mmss(9, 59), 1'b1, 1'b0);

        run_ticks(137, 1'b1);
        expect_now("mid_0742", mmss(7, 42), 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        expect_now("async_reset", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        cycle(1'b1, 1'b0, 1'b0, 1'b0, "load_drip");
        expect_now("drip_preset", mmss(30, 0), 1'b1, 1'b0);
        run_ticks(1740, 1'b0);
        expect_now("at_0100", mmss(1, 0), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "borrow_0100");
        expect_now("borrow_0059", mmss(0, 59), 1'b1, 1'b0);

        run_ticks(57, 1'b0);
        expect_now("at_0002", mmss(0, 2), 1'b1, 1'b0);
        run_ticks(2, 1'b0);
        expect_now("zero_reached", 0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "expire");
        expect_now("expired_pulse", 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, "done_tick");
        expect_now("done_quiet", 0, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 1'b1, 1'b0, "reload_in_done");
        expect_now("done_reload_3000", mmss(30, 0), 1'b1, 1'b0);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, "load_sprinkler2");
        run_ticks(150, 1'b1);
        expect_now("at_1230", mmss(12, 30), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, "pause_tick");
        expect_now("paused_1230", mmss(12, 30), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "unpause_edge");
        expect_now("resume_no_dec", mmss(12, 30), 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, "post_pause_tick");
        expect_now("resume_1229", mmss(12, 29), 1'b1, 1'b0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, "load_drip2");
        run_ticks(1483, 1'b0);
        expect_now("at_0517", mmss(5, 17), 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, "reload_with_tick");
        expect_now("reload_beats_tick", mmss(30, 0), 1'b1, 1'b0);

        checks++;
        assert (sb.size() === 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irrigation_countdown.md
Name: irrigation_countdown

Overview:
BCD MM:SS countdown timer that drives the irrigation cycle duration. It sits directly upstream of the timer reset logic and produces the minutes_d/minutes_u/seconds_d digits that logic monitors. Its synchronous reload input is driven by that logic's reset output, closing the loop. It loads a mode-dependent preset, decrements once per 1 Hz tick, and flags expiry.

Parameters:
SPRINKLER_PRESET, 16'h1500, packed BCD {md,mu,sd,su} loaded when splinker_mode_on=1 (15:00); md must be ≤3, sd ≤5, mu/su ≤9.
DRIP_PRESET, 16'h3000, packed BCD preset loaded when splinker_mode_on=0 (30:00); same legality rules.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle 1 Hz enable pulse
reload  in  1  synchronous reload request; level, held high keeps timer at preset
pause  in  1  freezes counting while high
splinker_mode_on  in  1  preset select: 1 = SPRINKLER_PRESET, 0 = DRIP_PRESET
minutes_d  out  2  minutes tens digit, 0..3
minutes_u  out  4  minutes units digit, 0..9
seconds_d  out  3  seconds tens digit, 0..5
seconds_u  out  4  seconds units digit, 0..9
running  out  1  high in RUN state
expired  out  1  one-cycle pulse on entry to DONE

Behaviour:
- All outputs registered. rst_n=0 (async): all digits 0, state IDLE, running=0, expired=0.
- States: IDLE, RUN, HOLD, DONE.
- Priority, highest first: rst_n, reload, pause, tick.
- reload=1 in any state: on the next edge, digits ← preset selected by splinker_mode_on in that cycle; state → RUN; expired=0. No decrement that cycle, even if tick=1.
- IDLE: digits hold 00:00; leaves only via reload.
- RUN:
  - Counter 00:00 (and no reload): → DONE; expired=1 for exactly one cycle.
  - Else pause=1: → HOLD; no decrement, even if tick=1.
  - Else tick=1: decrement by one second.
- HOLD: digits frozen; ticks ignored. pause=0 → RUN on the next edge; ticks in that transition cycle are ignored.
- DONE: digits held at 00:00; running=0; ticks ignored; leaves only via reload.
- Decrement is a BCD borrow chain:
  - su: 0→9 with borrow, else su−1.
  - sd: on borrow, 0→5 with borrow, else sd−1.
  - mu: on borrow, 0→9 with borrow, else mu−1.
  - md: on borrow, md−1.
  - 00:00 is never decremented; no wrap to 39:59.
- Expiry latency: tick at 00:01 → digits 00:00 at edge N; state DONE with expired=1 at edge N+1.
- A preset of 00:00 loads into RUN, then enters DONE with an expired pulse one cycle later.
- Digits never leave their legal ranges; illegal preset parameters are an elaboration error (assertion).
- running = (state==RUN). HOLD and DONE report running=0.

Decomposition:
- Package irrigation_timer_pkg holds:
  - state enum (IDLE, RUN, HOLD, DONE);
  - digit max constants (MD_MAX=3, MU_MAX=9, SD_MAX=5, SU_MAX=9);
  - default preset constants;
  - preset field-extraction helpers.
- Sub-module bcd_digit_down, instantiated four times.
  - Parameters: WIDTH, MAX.
  - Ports: clk, rst_n, load, load_val, dec_in (borrow request), digit, borrow_out.
  - borrow_out = dec_in & (digit==0).
- The top level owns the FSM, the zero detect and the preset mux.

Test Plan:
- Reset with rst_n=0 mid-count at 07:42 → digits 00:00, running=0, state IDLE immediately, without waiting for a clk edge.
- reload=1 with splinker_mode_on=1, then release → digits 15:00, running=1. One tick → 14:59. With splinker_mode_on=0 → 30:00.
- Borrow chain: load preset 16'h1000, apply one tick → 09:59. Load 16'h0100, tick → 00:59.
- Expiry: count down from preset 16'h0002 with two ticks → 00:00. Next cycle expired=1 for one cycle, running=0. A further 5 ticks → still 00:00, expired stays 0.
- Pause: at 12:30 assert pause together with tick for 3 ticks → digits stay 12:30, running=0. Deassert pause → next tick gives 12:29.
- Simultaneous reload and tick at 05:17 (mode 0) → 30:00 exactly, no decrement. reload asserted in DONE → 30:00, state RUN.
